// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: frame FSM states, parity modes and the buffered word layout shared by the UART receiver
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  localparam int MAX_PAYLOAD = 9;
  typedef struct packed {
    logic                   frame_err;
    logic                   parity_err;
    logic [MAX_PAYLOAD-1:0] data;
  } rx_word_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO; push and pop may coincide even when full
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0] r_cnt;
  logic w_pop;
  logic w_push;
  assign o_valid = r_cnt != '0;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign w_pop = i_pop && o_valid;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_data = o_valid ? r_mem[r_rd] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver feeding a FIFO; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BIT_RATE = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic                    RX_D_I,
  input  logic                    RX_EN_I,
  output logic [PAYLOAD_BITS-1:0] DATA_O,
  output logic                    VALID_O,
  input  logic                    READY_I,
  output logic                    PARITY_ERR_O,
  output logic                    FRAME_ERR_O,
  output logic                    OVERFLOW_O,
  output logic                    BUSY_O
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = HALF + 1;
`else
  localparam int DEC = HALF;
`endif
  rx_state_t r_state;
  rx_state_t w_next;
  logic [1:0] r_sync;
  logic r_prev;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic r_par;
  logic r_ferr;
  logic r_ovf;
  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_bit;
  logic w_last;
  logic w_stop_err;
  logic w_perr;
  logic w_push;
  logic w_full;
  rx_word_t w_word;
  rx_word_t w_head;
  assign w_rx = r_sync[1];
  assign w_fall = r_prev && !w_rx;
  assign w_tick = r_cnt == CW'(DEC);
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;
  // decision lands at HALF+1: history holds the HALF-1 and HALF samples
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
  always_ff @(posedge CLK_I) begin
    r_hist <= !RST_N_I ? 2'b11 : {r_hist[0], w_rx};
  end
`else
  assign w_bit = w_rx;
`endif
  assign w_last = r_idx == 4'((r_state == STOP ? STOP_BITS : PAYLOAD_BITS) - 1);
  assign w_stop_err = r_ferr | !w_bit;
  assign w_perr = (PARITY_MODE == PAR_ODD) ? ~(^{r_shift, r_par}) :
                  (PARITY_MODE == PAR_EVEN) ? ^{r_shift, r_par} : 1'b0;
  always_ff @(posedge CLK_I) begin
    r_state <= !RST_N_I ? IDLE : w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = (w_fall && RX_EN_I) ? START : IDLE;
      START: if (w_tick) w_next = w_bit ? IDLE : DATA;
      DATA: if (w_tick && w_last) w_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      PARITY: if (w_tick) w_next = STOP;
      STOP: if (w_tick && w_last) w_next = w_stop_err ? BREAK : IDLE;
      BREAK: if (w_rx) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_push = r_state == STOP && w_tick && w_last;
    BUSY_O = r_state != IDLE;
  end
  // the bit counter free-runs through a frame so every tick sits mid-bit
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_par <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], RX_D_I};
      r_prev <= w_rx;
      r_cnt <= (r_state == IDLE || r_state == BREAK || r_cnt == CW'(CPB - 1)) ? '0 : r_cnt + 1'b1;
      r_idx <= (w_next != r_state) ? '0 : (w_tick ? r_idx + 1'b1 : r_idx);
      if (r_state == DATA && w_tick) r_shift <= {w_bit, r_shift[PAYLOAD_BITS-1:1]};
      if (r_state == PARITY && w_tick) r_par <= w_bit;
      if (r_state == START) r_ferr <= 1'b0;
      else if (r_state == STOP && w_tick) r_ferr <= w_stop_err;
      if (w_push && w_full && !(VALID_O && READY_I)) r_ovf <= 1'b1;
    end
  end
  always_comb begin
    w_word.frame_err = w_stop_err;
    w_word.parity_err = w_perr;
    w_word.data = MAX_PAYLOAD'(r_shift);
  end
  uart_rx_fifo #(
    .WIDTH($bits(rx_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(CLK_I),
    .rst_n(RST_N_I),
    .i_push(w_push),
    .i_data(w_word),
    .i_pop(READY_I),
    .o_data(w_head),
    .o_valid(VALID_O),
    .o_full(w_full)
  );
  assign DATA_O = PAYLOAD_BITS'(w_head.data);
  assign PARITY_ERR_O = w_head.parity_err;
  assign FRAME_ERR_O = w_head.frame_err;
  assign OVERFLOW_O = r_ovf;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized frames on a no-parity and an even-parity receiver against a frame-level model
module tb_uart_rx_param;
  localparam int CLK_HZ = 50_000_000;
  localparam int BIT_RATE = 500_000;
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic en = 1'b1;
  logic rdy_a = 1'b1;
  logic rdy_b = 1'b1;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, ovf_a, ovf_b, busy_a, busy_b;
  int checks = 0;
  int failures = 0;
  logic [9:0] pops_a[$];
  logic [9:0] pops_b[$];
  int rises_a = 0;
  logic prev_valid_a = 1'b0;

  always #10 clk = ~clk;

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) u_a (
    .CLK_I(clk), .RST_N_I(rst_n), .RX_D_I(rx_a), .RX_EN_I(en),
    .DATA_O(data_a), .VALID_O(valid_a), .READY_I(rdy_a),
    .PARITY_ERR_O(perr_a), .FRAME_ERR_O(ferr_a), .OVERFLOW_O(ovf_a), .BUSY_O(busy_a)
  );
  uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PARITY_MODE(2)) u_b (
    .CLK_I(clk), .RST_N_I(rst_n), .RX_D_I(rx_b), .RX_EN_I(1'b1),
    .DATA_O(data_b), .VALID_O(valid_b), .READY_I(rdy_b),
    .PARITY_ERR_O(perr_b), .FRAME_ERR_O(ferr_b), .OVERFLOW_O(ovf_b), .BUSY_O(busy_b)
  );

  always @(negedge clk) begin
    if (valid_a && rdy_a) pops_a.push_back({ferr_a, perr_a, data_a});
    if (valid_b && rdy_b) pops_b.push_back({ferr_b, perr_b, data_b});
    if (valid_a && !prev_valid_a) rises_a++;
    prev_valid_a = valid_a;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic drive(input bit b, input logic v, input int cycles);
    if (b) rx_b = v;
    else rx_a = v;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic send(input bit b, input logic [7:0] d, input bit has_par, input logic pbit);
    drive(b, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b, d[i], CPB);
    if (has_par) drive(b, pbit, CPB);
    drive(b, 1'b1, CPB);
  endtask

  task automatic wait_pops(input bit b, input int n);
    for (int i = 0; i < 4 * CPB; i++) begin
      if ((b ? pops_b.size() : pops_a.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_a); end
    checks++; if (perr_a !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", perr_a); end
    checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", ferr_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [3] = '{8'hA5, 8'h00, 8'hFF};
    int r0 = rises_a;
    pops_a.delete();
    foreach (bytes[i]) send(1'b0, bytes[i], 1'b0, 1'b0);
    wait_pops(1'b0, 3);
    checks++; if (pops_a.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", pops_a.size()); end
    for (int i = 0; i < 3 && i < pops_a.size(); i++) begin
      checks++;
      if (pops_a[i] !== {2'b00, bytes[i]}) begin failures++; $display("FAIL basic_word idx=%0d got=%h exp=%h", i, pops_a[i], {2'b00, bytes[i]}); end
    end
    checks++; if (rises_a - r0 != 3) begin failures++; $display("FAIL basic_valid_pulses got=%0d exp=3", rises_a - r0); end
  endtask

  task automatic test_random();
    logic [9:0] exp[$];
    pops_a.delete();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d = 8'($urandom_range(0, 255));
      send(1'b0, d, 1'b0, 1'b0);
      exp.push_back({2'b00, d});
      repeat ($urandom_range(0, 2 * CPB)) @(posedge clk);
    end
    wait_pops(1'b0, exp.size());
    checks++; if (pops_a.size() != exp.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", pops_a.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < pops_a.size(); i++) begin
      checks++;
      if (pops_a[i] !== exp[i]) begin failures++; $display("FAIL random_word idx=%0d got=%h exp=%h", i, pops_a[i], exp[i]); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d_q[$] = '{8'h07, 8'h07};
    logic p_q[$] = '{1'b0, 1'b1};
    logic [9:0] exp[$];
    for (int k = 0; k < 4; k++) begin
      d_q.push_back(8'($urandom_range(0, 255)));
      p_q.push_back(1'($urandom_range(0, 1)));
    end
    pops_b.delete();
    foreach (d_q[i]) begin
      send(1'b1, d_q[i], 1'b1, p_q[i]);
      // even parity: data plus parity bit must hold an even number of ones
      exp.push_back({1'b0, (^d_q[i]) ^ p_q[i], d_q[i]});
    end
    wait_pops(1'b1, exp.size());
    checks++; if (pops_b.size() != exp.size()) begin failures++; $display("FAIL parity_count got=%0d exp=%0d", pops_b.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < pops_b.size(); i++) begin
      checks++;
      if (pops_b[i] !== exp[i]) begin failures++; $display("FAIL parity_word idx=%0d got=%h exp=%h", i, pops_b[i], exp[i]); end
    end
    checks++; if (pops_b.size() > 1 && pops_b[0][8] !== 1'b1) begin failures++; $display("FAIL parity_07_p0 got=%b exp=1", pops_b[0][8]); end
    checks++; if (pops_b.size() > 1 && pops_b[1][8] !== 1'b0) begin failures++; $display("FAIL parity_07_p1 got=%b exp=0", pops_b[1][8]); end
  endtask

  task automatic test_break();
    logic [7:0] d = 8'h3C;
    pops_a.delete();
    drive(1'b0, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(1'b0, d[i], CPB);
    drive(1'b0, 1'b0, CPB + HALF);
    @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", busy_a); end
    checks++; if (pops_a.size() != 1 || pops_a[0] !== 10'h23C) begin failures++; $display("FAIL break_word n=%0d got=%h exp=23c", pops_a.size(), pops_a.size() > 0 ? pops_a[0] : 10'h0); end
    drive(1'b0, 1'b0, HALF);
    drive(1'b0, 1'b1, 6);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL break_exit_busy got=%b exp=0", busy_a); end
    drive(1'b0, 1'b1, CPB);
    send(1'b0, 8'h5A, 1'b0, 1'b0);
    wait_pops(1'b0, 2);
    checks++; if (pops_a.size() != 2 || pops_a[1] !== 10'h05A) begin failures++; $display("FAIL break_next n=%0d got=%h exp=05a", pops_a.size(), pops_a.size() > 1 ? pops_a[1] : 10'h0); end
  endtask

  task automatic test_overflow();
    logic [9:0] mdl[$];
    logic exp_ovf = 1'b0;
    pops_a.delete();
    rdy_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      send(1'b0, 8'(k), 1'b0, 1'b0);
      if (mdl.size() < DEPTH) mdl.push_back({2'b00, 8'(k)});
      else exp_ovf = 1'b1;
    end
    @(negedge clk);
    checks++; if (ovf_a !== exp_ovf) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", ovf_a, exp_ovf); end
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", valid_a); end
    repeat (10) @(negedge clk);
    checks++; if ({ferr_a, perr_a, data_a} !== mdl[0]) begin failures++; $display("FAIL ovf_head_hold got=%h exp=%h", {ferr_a, perr_a, data_a}, mdl[0]); end
    rdy_a = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (pops_a.size() != mdl.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", pops_a.size(), mdl.size()); end
    for (int i = 0; i < mdl.size() && i < pops_a.size(); i++) begin
      checks++;
      if (pops_a[i] !== mdl[i]) begin failures++; $display("FAIL ovf_word idx=%0d got=%h exp=%h", i, pops_a[i], mdl[i]); end
    end
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf_a); end
  endtask

  task automatic test_glitch();
    int n = 0;
    bit seen = 1'b0;
    pops_a.delete();
    fork
      begin
        rx_a = 1'b0;
        repeat (25) @(posedge clk);
        rx_a = 1'b1;
      end
    join_none
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = busy_a;
    end
    while (busy_a && n < 2 * CPB) begin
      @(negedge clk);
      n++;
    end
    checks++; if (!seen) begin failures++; $display("FAIL glitch_busy_rise got=0 exp=1"); end
    checks++; if (n > HALF + 3 || n < HALF - 2) begin failures++; $display("FAIL glitch_busy_len got=%0d exp=%0d..%0d", n, HALF - 2, HALF + 3); end
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    checks++; if (pops_a.size() != 0 || valid_a !== 1'b0) begin failures++; $display("FAIL glitch_no_push got=%0d exp=0", pops_a.size()); end
  endtask

  task automatic test_enable();
    pops_a.delete();
    en = 1'b0;
    send(1'b0, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (pops_a.size() != 0 || busy_a !== 1'b0) begin failures++; $display("FAIL enable_off got=%0d busy=%b exp=0", pops_a.size(), busy_a); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'h99;
    pops_a.delete();
    drive(1'b0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b0, d[i], CPB);
    drive(1'b0, d[4], HALF);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_a, data_a, perr_a, ferr_a, ovf_a, busy_a} !== 13'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=v%b d%h p%b f%b o%b b%b exp=all 0", valid_a, data_a, perr_a, ferr_a, ovf_a, busy_a);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 3 * CPB);
    checks++; if (pops_a.size() != 0 || busy_a !== 1'b0) begin failures++; $display("FAIL midreset_discard got=%0d busy=%b exp=0", pops_a.size(), busy_a); end
    send(1'b0, 8'h42, 1'b0, 1'b0);
    wait_pops(1'b0, 1);
    checks++; if (pops_a.size() != 1 || pops_a[0] !== 10'h042) begin failures++; $display("FAIL midreset_next n=%0d got=%h exp=042", pops_a.size(), pops_a.size() > 0 ? pops_a[0] : 10'h0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_parity();
    test_break();
    test_overflow();
    test_glitch();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, meaning line rate in b/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning receive words buffered, power of 2, at least 2.
REQ-007 SHALL have port CLK_I, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-008 SHALL have port RST_N_I, input, 1, meaning synchronous active-low reset.
REQ-009 SHALL have port RX_D_I, input, 1, meaning asynchronous serial line, idle high.
REQ-010 SHALL have port RX_EN_I, input, 1, meaning receiver enable.
REQ-011 SHALL have port DATA_O, output, PAYLOAD_BITS, meaning FIFO head data, LSB is the first bit received.
REQ-012 SHALL have port VALID_O, output, 1, meaning the FIFO head is valid.
REQ-013 SHALL have port READY_I, input, 1, meaning the consumer accepts the head; a pop occurs when VALID_O and READY_I are both high.
REQ-014 SHALL have port PARITY_ERR_O, output, 1, meaning the head word failed its parity check.
REQ-015 SHALL have port FRAME_ERR_O, output, 1, meaning the head word had a stop bit sampled low.
REQ-016 SHALL have port OVERFLOW_O, output, 1, meaning sticky: at least one word was dropped because the FIFO was full.
REQ-017 SHALL have port BUSY_O, output, 1, meaning the frame FSM is not in IDLE.

Function
REQ-018 SHALL pass RX_D_I through a 2-FF synchroniser before any use.
REQ-019 SHALL compute CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer floor) and HALF = CYCLES_PER_BIT/2; counter width = $clog2(CYCLES_PER_BIT+1).
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE->START: synchronised line falls while RX_EN_I=1.
- START: after HALF cycles, line low -> DATA; line high -> IDLE (glitch, no push).
- DATA: one sample every CYCLES_PER_BIT; after PAYLOAD_BITS samples -> PARITY if PARITY_MODE!=0, else STOP.
- PARITY: one sample -> STOP.
- STOP: STOP_BITS samples, then push the word.
- STOP exit: all stop bits high -> IDLE; any stop bit low -> BREAK.
- BREAK: wait for line high -> IDLE.
REQ-021 SHALL push {FRAME_ERR, PARITY_ERR, data} at the cycle the last stop bit is sampled; VALID_O SHALL rise the next cycle when the FIFO was empty.
REQ-022 SHALL compute PARITY_ERR as follows: odd mode -> XOR(data, parity bit) != 1; even mode -> XOR != 0; none -> 0.
REQ-023 SHALL, when RX_EN_I deasserts mid-frame, complete the current frame; RX_EN_I SHALL gate only the IDLE->START transition.
REQ-024 SHALL, on a push while the FIFO is full with no pop in the same cycle, drop the new word, keep the FIFO contents, and set OVERFLOW_O.
REQ-025 SHALL, on a push and a pop in the same cycle, perform both operations, including when the FIFO is full.
REQ-026 SHALL hold DATA_O, PARITY_ERR_O and FRAME_ERR_O stable while VALID_O=1 and READY_I=0.

Reset
REQ-027 SHALL, while RST_N_I=0 at a clock edge, force FSM=IDLE, counters=0, FIFO empty, synchroniser=1, VALID_O=0, DATA_O=0, PARITY_ERR_O=0, FRAME_ERR_O=0, OVERFLOW_O=0, BUSY_O=0.
REQ-028 SHALL, on reset mid-frame, discard the partial frame; after release, the next falling edge starts a new frame.

Configuration
REQ-029 SHALL, with UART_RX_MAJORITY_EN defined, decide each bit by 2-of-3 majority of samples at HALF-1, HALF and HALF+1 cycles into the bit; without it, the decision is the single sample at HALF.

Structure
REQ-030 SHALL place the FSM state enum, the parity-mode localparams (PAR_NONE, PAR_ODD, PAR_EVEN) and the FIFO word struct in package uart_rx_pkg.
REQ-031 SHALL instantiate the buffer as sub-module uart_rx_fifo (parametrised width/depth, synchronous, first-word-fall-through).

Verification
REQ-032 SHALL cover: defaults, bytes 0xA5, 0x00, 0xFF sent with READY_I=1 -> DATA_O matches each, no error flags, VALID_O pulses once per byte.
REQ-033 SHALL cover: PARITY_MODE=2, byte 0x07 sent with parity bit 0 -> PARITY_ERR_O=1; parity bit 1 -> PARITY_ERR_O=0.
REQ-034 SHALL cover: stop bit driven low for 0x3C, then line high after 2 bit times -> word 0x3C with FRAME_ERR_O=1, FSM passes through BREAK, the next byte 0x5A is received clean.
REQ-035 SHALL cover: READY_I=0, six bytes 0x01..0x06 sent, FIFO_DEPTH=4 -> OVERFLOW_O=1; after READY_I=1, words 0x01..0x04 are popped in order.
REQ-036 SHALL cover: a 500 ns low glitch on an idle line -> no push, BUSY_O returns low by HALF+3 cycles.
REQ-037 SHALL cover: RST_N_I=0 asserted during bit 4 of 0x99 -> all outputs 0; the following byte 0x42 is received correctly.
